multi_blink: RTL and testbench
==============================

MULTI_BLINK -- requirements
Module: multi_blink

Interface
REQ-001 Parameter CBITS, default 16: width of each channel's counter and period register.
REQ-002 Parameter NCH, default 4: number of independent channels, legal range 1..16.
REQ-003 Parameter AW, default 2: width of cfg_ch; SHALL satisfy 2**AW >= NCH.
REQ-004 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 cfg_we  input  1  configuration write strobe, sampled on a clk edge.
REQ-007 cfg_ch  input  AW  channel index for the write.
REQ-008 cfg_mode  input  2  mode code: 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
REQ-009 cfg_period  input  CBITS  period value for the write.
REQ-010 sync  input  1  global restart strobe for running channels.
REQ-011 led  output  NCH  registered LED level, one bit per channel.
REQ-012 flg  output  NCH  registered one-cycle event pulse, one bit per channel.

Function
REQ-013 Each channel SHALL hold the state mode_r[1:0], period_r[CBITS-1:0], cnt[CBITS-1:0] and phase; channels SHALL be fully independent except for sync.
REQ-014 Write: when cfg_we=1 and cfg_ch<NCH, the channel SHALL load mode_r<=cfg_mode and period_r<=cfg_period, and SHALL clear cnt, phase, led and flg on the same edge.
REQ-015 When cfg_ch>=NCH, the write SHALL be ignored with no state change.
REQ-016 OFF: cnt held at 0; led<=0; flg<=0.
REQ-017 ON: cnt held at 0; led<=1; flg<=0.
REQ-018 BLINK, cnt!=period_r: cnt<=cnt+1; flg<=0; led unchanged.
REQ-019 BLINK, cnt==period_r: cnt<=0; phase<=~phase; led<=~phase; flg<=1. Resulting half-period = period_r+1 cycles; full period = 2*(period_r+1).
REQ-020 BLINK with period_r=0: led SHALL toggle every cycle and flg SHALL stay 1 continuously.
REQ-021 ONESHOT, first edge after the write: led<=1; cnt counts as in BLINK.
REQ-022 ONESHOT, cnt==period_r: led<=0; flg<=1 for one cycle; mode_r<=OFF. led high time = period_r+1 cycles.
REQ-023 Counter arithmetic SHALL be modulo 2**CBITS; with period_r = all-ones, cnt reaches the maximum value and then wraps to 0 as the terminal event.
REQ-024 sync=1: every channel in BLINK or ONESHOT that is not being written on that edge SHALL set cnt<=0, phase<=0, led<=0 (ONESHOT: led<=1), flg<=0.
REQ-025 Simultaneous cfg_we and sync: the write SHALL take priority for the addressed channel; sync SHALL apply to all other channels.
REQ-026 When period_r>=1 in BLINK, flg SHALL never be 1 on two consecutive cycles.
REQ-027 When period_r>=1 in BLINK, led SHALL be constant for exactly period_r+1 cycles between toggles.

Reset
REQ-028 On rst=1, each channel SHALL immediately set mode_r=OFF, period_r=all-ones, cnt=0, phase=0, led=0, flg=0, regardless of clk.
REQ-029 Reset asserted mid-blink or mid-oneshot SHALL abort the operation; after release the channel SHALL stay OFF until written.
REQ-030 cfg_we and sync SHALL have no effect while rst=1.

Verification
REQ-031 Write ch0 BLINK, period=3 -> led0 0 for 4 cycles, 1 for 4 cycles, repeating; flg0 pulses every 4 cycles, coincident with each led0 edge.
REQ-032 Write ch1 ONESHOT, period=5 -> led1 1 for 6 cycles then 0; single flg1 pulse on the falling edge; ch1 reads OFF afterwards.
REQ-033 ch0 BLINK period=0 and ch2 ON -> led0 toggles every cycle with flg0 held at 1; led2 constant 1 with flg2 0.
REQ-034 ch0 and ch3 BLINK period=9, sync pulsed at cycle 4 together with a write to ch3 of period=2 -> ch0 restarts its count from 0; ch3 follows the new period 2; no stray flg pulses.
REQ-035 Write with cfg_ch=3 when NCH=3 (AW=2) -> all state unchanged; then rst asserted between clock edges mid-blink -> led and flg go to 0 immediately and the channel stays OFF after release.
REQ-036 Run CBITS=4 BLINK period=15 -> wrap-around at 15->0 toggles led every 16 cycles; the REQ-026 flg property holds throughout.

Source files
------------

// File: rtl/multi_blink.sv
// multi_blink: NCH independent LED channels, each OFF / ON / BLINK / ONESHOT.
// Each channel has a configurable period. A global sync strobe restarts the
// channels that are currently running.
//
// Channel mode table (mode_q):
//   state        | meaning
//   MODE_OFF     | led held low, counter idle
//   MODE_ON      | led held high, counter idle
//   MODE_BLINK   | led toggles every period_q+1 cycles, flg on each toggle
//   MODE_ONESHOT | led high for period_q+1 cycles, then flg pulse and OFF
module multi_blink #(
   parameter int CBITS = 16,
   parameter int NCH   = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [CBITS-1:0] cfg_period,
   input  logic             sync,
   output logic [NCH-1:0]   led,
   output logic [NCH-1:0]   flg
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_e;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      mode_e            mode_q, mode_d;
      logic [CBITS-1:0] period_q, period_d;
      logic [CBITS-1:0] cnt_q, cnt_d;
      logic             phase_q, phase_d;
      logic             led_q, led_d;
      logic             flg_q, flg_d;
      logic             wr_hit;
      logic             running;
      logic             term;

      // Out-of-range channel indices never match any channel, so those writes drop.
      assign wr_hit  = cfg_we && (cfg_ch == AW'(i));
      assign running = (mode_q == MODE_BLINK) || (mode_q == MODE_ONESHOT);
      assign term    = (cnt_q == period_q);

      // Channel state register; reset parks the channel in OFF with maximum period.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '1;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= 1'b0;
            flg_q    <= 1'b0;
         end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
            flg_q    <= flg_d;
         end
      end

      // Next-state: a write beats sync, and sync beats normal mode behaviour.
      always_comb begin
         mode_d   = mode_q;
         period_d = period_q;
         cnt_d    = cnt_q;
         phase_d  = phase_q;
         led_d    = led_q;
         flg_d    = 1'b0;
         if (wr_hit) begin
            mode_d   = mode_e'(cfg_mode);
            period_d = cfg_period;
            cnt_d    = '0;
            phase_d  = 1'b0;
            led_d    = 1'b0;
         end else if (sync && running) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            led_d   = (mode_q == MODE_ONESHOT);
         end else begin
            unique case (mode_q)
               MODE_OFF: begin
                  cnt_d = '0;
                  led_d = 1'b0;
               end
               MODE_ON: begin
                  cnt_d = '0;
                  led_d = 1'b1;
               end
               MODE_BLINK: begin
                  if (term) begin
                     cnt_d   = '0;
                     phase_d = ~phase_q;
                     led_d   = ~phase_q;
                     flg_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               MODE_ONESHOT: begin
                  // led low here means this is the first edge after the write:
                  // raise led without counting so the high time is period_q+1.
                  if (!led_q) begin
                     led_d = 1'b1;
                  end else if (term) begin
                     cnt_d  = '0;
                     led_d  = 1'b0;
                     flg_d  = 1'b1;
                     mode_d = MODE_OFF;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  mode_d = MODE_OFF;
               end
            endcase
         end
      end

      assign led[i] = led_q;
      assign flg[i] = flg_q;
   end

endmodule

// File: tb/tb_multi_blink.sv
// Bench for multi_blink: directed scenarios plus random traffic, checked
// against an elapsed-time model of each channel.
module tb_multi_blink;

   localparam int CBITS = 4;
   localparam int NCH   = 4;
   localparam int AW    = 3;

   logic             clk;
   logic             rst;
   logic             cfg_we;
   logic [AW-1:0]    cfg_ch;
   logic [1:0]       cfg_mode;
   logic [CBITS-1:0] cfg_period;
   logic             sync;
   logic [NCH-1:0]   led;
   logic [NCH-1:0]   flg;

   multi_blink #(.CBITS(CBITS), .NCH(NCH), .AW(AW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .sync       (sync),
      .led        (led),
      .flg        (flg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: per channel the mode, period, edges elapsed since the last
   // (re)start k, and whether the start was a write (1) or a sync (0).
   int m_mode [NCH];
   int m_p    [NCH];
   int m_k    [NCH];
   int m_hi   [NCH];
   logic [NCH-1:0] exp_led;
   logic [NCH-1:0] exp_flg;

   int n_pass;
   int n_total;

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_mode[i] = 0;
         m_p[i]    = (1 << CBITS) - 1;
         m_k[i]    = 0;
         m_hi[i]   = 1;
      end
      exp_led = '0;
      exp_flg = '0;
   endtask

   task automatic model_step();
      for (int i = 0; i < NCH; i++) begin
         int h;
         int e;
         if (cfg_we && int'(cfg_ch) == i) begin
            m_mode[i] = int'(cfg_mode);
            m_p[i]    = int'(cfg_period);
            m_k[i]    = 0;
            m_hi[i]   = 1;
         end else if (sync && m_mode[i] >= 2) begin
            m_k[i]  = 0;
            m_hi[i] = 0;
         end else begin
            m_k[i]++;
         end
         exp_led[i] = 1'b0;
         exp_flg[i] = 1'b0;
         case (m_mode[i])
            1: exp_led[i] = (m_k[i] >= 1);
            2: begin
               h = m_p[i] + 1;
               exp_led[i] = ((m_k[i] / h) % 2) == 1;
               exp_flg[i] = (m_k[i] > 0) && (m_k[i] % h == 0);
            end
            3: begin
               e = m_p[i] + 1 + m_hi[i];
               if (m_k[i] == e) begin
                  exp_flg[i] = 1'b1;
                  m_mode[i]  = 0;
               end else begin
                  exp_led[i] = (m_k[i] >= m_hi[i]);
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic we, input int ch, input int mode,
                         input int period, input logic sy);
      cfg_we     = we;
      cfg_ch     = AW'(ch);
      cfg_mode   = 2'(mode);
      cfg_period = CBITS'(period);
      sync       = sy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, 0, 0, 0, 1'b0);
      model_reset();
      #1;
      if (led !== exp_led) $display("FAIL reset_led got=%b exp=%b", led, exp_led);
      else n_pass++;
      n_total++;
      if (flg !== exp_flg) $display("FAIL reset_flg got=%b exp=%b", flg, exp_flg);
      else n_pass++;
      n_total++;
      #7 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         if (led !== exp_led) $display("FAIL reset_idle_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
      end
   endtask

   task automatic test_blink();
      set_in(1'b1, 0, 2, 3, 1'b0);
      for (int c = 0; c < 20; c++) begin
         cycle();
         set_in(1'b0, 0, 0, 0, 1'b0);
         if (led !== exp_led) $display("FAIL blink_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL blink_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
   endtask

   task automatic test_oneshot();
      int hi_cnt;
      int flg_cnt;
      hi_cnt  = 0;
      flg_cnt = 0;
      set_in(1'b1, 1, 3, 5, 1'b0);
      for (int c = 0; c < 14; c++) begin
         cycle();
         set_in(1'b0, 0, 0, 0, 1'b0);
         hi_cnt  += int'(led[1]);
         flg_cnt += int'(flg[1]);
         if (led !== exp_led) $display("FAIL oneshot_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL oneshot_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
      if (hi_cnt !== 6) $display("FAIL oneshot_high_time got=%0d exp=6", hi_cnt);
      else n_pass++;
      n_total++;
      if (flg_cnt !== 1) $display("FAIL oneshot_pulses got=%0d exp=1", flg_cnt);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_fast_and_on();
      set_in(1'b1, 0, 2, 0, 1'b0);
      cycle();
      set_in(1'b1, 2, 1, 7, 1'b0);
      for (int c = 0; c < 10; c++) begin
         cycle();
         set_in(1'b0, 0, 0, 0, 1'b0);
         if (led !== exp_led) $display("FAIL fast_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL fast_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
   endtask

   task automatic test_sync_write();
      set_in(1'b1, 0, 2, 9, 1'b0);
      cycle();
      set_in(1'b1, 3, 2, 9, 1'b0);
      cycle();
      set_in(1'b0, 0, 0, 0, 1'b0);
      cycle();
      cycle();
      set_in(1'b1, 3, 2, 2, 1'b1);
      for (int c = 0; c < 30; c++) begin
         cycle();
         set_in(1'b0, 0, 0, 0, 1'b0);
         if (led !== exp_led) $display("FAIL sync_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL sync_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
   endtask

   task automatic test_ignore_and_abort();
      set_in(1'b1, 0, 2, 2, 1'b0);
      cycle();
      set_in(1'b0, 0, 0, 0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         if (c == 4) set_in(1'b1, 4 + (c % 4), 1, 0, 1'b0);
         cycle();
         set_in(1'b0, 0, 0, 0, 1'b0);
         if (led !== exp_led) $display("FAIL ignore_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL ignore_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
      #3;
      rst = 1'b1;
      set_in(1'b1, 0, 2, 1, 1'b1);
      model_reset();
      #1;
      if (led !== exp_led) $display("FAIL abort_led_now got=%b exp=%b", led, exp_led);
      else n_pass++;
      n_total++;
      if (flg !== exp_flg) $display("FAIL abort_flg_now got=%b exp=%b", flg, exp_flg);
      else n_pass++;
      n_total++;
      repeat (2) @(posedge clk);
      #3;
      set_in(1'b0, 0, 0, 0, 1'b0);
      #1 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (led !== exp_led) $display("FAIL abort_idle_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL abort_idle_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
   endtask

   task automatic test_wrap();
      int toggles;
      logic prev;
      toggles = 0;
      set_in(1'b1, 2, 2, 15, 1'b0);
      cycle();
      set_in(1'b0, 0, 0, 0, 1'b0);
      prev = led[2];
      for (int c = 0; c < 40; c++) begin
         cycle();
         if (led[2] != prev) toggles++;
         prev = led[2];
         if (led !== exp_led) $display("FAIL wrap_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL wrap_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
      end
      if (toggles !== 2) $display("FAIL wrap_toggles got=%0d exp=2", toggles);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_random();
      logic [NCH-1:0] prev_flg;
      prev_flg = flg;
      for (int c = 0; c < 400; c++) begin
         set_in(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                ($urandom_range(0, 15) == 0));
         cycle();
         set_in(1'b0, 0, 0, 0, 1'b0);
         if (led !== exp_led) $display("FAIL rand_led cyc=%0d got=%b exp=%b", c, led, exp_led);
         else n_pass++;
         n_total++;
         if (flg !== exp_flg) $display("FAIL rand_flg cyc=%0d got=%b exp=%b", c, flg, exp_flg);
         else n_pass++;
         n_total++;
         for (int i = 0; i < NCH; i++) begin
            if (m_mode[i] == 2 && m_p[i] >= 1) begin
               if (flg[i] === 1'b1 && prev_flg[i] === 1'b1)
                  $display("FAIL rand_flg_back_to_back cyc=%0d ch=%0d got=11 exp=not 11", c, i);
               else n_pass++;
               n_total++;
            end
         end
         prev_flg = flg;
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_blink();
      test_oneshot();
      test_fast_and_on();
      test_sync_write();
      test_ignore_and_abort();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
